// File: rtl/pe_operand_feeder.sv
// Operand sequencer for one FP16 MAC PE: buffers weight/input vectors and streams pairs.
// Optional macro ZERO_SKIP_EN: pairs with a zero (+/-0) weight or input are not issued.
module pe_operand_feeder #(
   parameter int DW     = 16,
   parameter int DEPTH  = 16,
   parameter int AW     = 4,
   parameter int PE_LAT = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic          wr_sel,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic [AW:0]   cfg_len,
   input  logic [DW-1:0] cfg_bias,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] o_wgt,
   output logic [DW-1:0] o_ipt,
   output logic [DW-1:0] o_psum,
   output logic          o_accum_ctr,
   output logic          o_valid
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_STREAM = 2'd1;
   localparam logic [1:0] S_DRAIN  = 2'd2;
   localparam int AW1 = AW + 1;
   localparam int CW  = $clog2(PE_LAT + 1);

   logic [1:0]    state, state_n;
   logic [AW:0]   len_r;
   logic [AW:0]   ptr, ptr_n;
   logic [CW-1:0] dcnt, dcnt_n;
   logic [DW-1:0] bias_r;
   logic          start_q;

   logic [DW-1:0] wgt_mem [DEPTH];
   logic [DW-1:0] ipt_mem [DEPTH];
   logic [DW-1:0] wgt_eff [DEPTH];
   logic [DW-1:0] ipt_eff [DEPTH];

   logic             wr_ok, start_acc, issue, more;
   logic [AW:0]      len_cfg, len_use, from_idx, j1, j2;
   logic [AW-1:0]    pick;
   logic [DEPTH-1:0] issuable;
   logic [DW-1:0]    wgt_n, ipt_n, psum_n;
   logic             ctr_n, valid_n, done_n;

   // Lowest set bit of m at or above 'from'; DEPTH when there is none.
   function automatic logic [AW:0] find_next(input logic [DEPTH-1:0] m, input logic [AW:0] from);
      logic [AW:0] r;
      r = AW1'(DEPTH);
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (m[i] && (AW1'(i) >= from)) r = AW1'(i);
      end
      return r;
   endfunction

   assign wr_ok     = wr_en && (state == S_IDLE);
   assign start_acc = start && !start_q && (state == S_IDLE);
   assign len_cfg   = (cfg_len > AW1'(DEPTH)) ? AW1'(DEPTH) : cfg_len;
   assign len_use   = (state == S_IDLE) ? len_cfg : len_r;
   assign from_idx  = (state == S_IDLE) ? '0 : ptr;
   assign busy      = (state != S_IDLE);

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         if (wr_sel) ipt_mem[wr_addr] <= wr_data;
         else        wgt_mem[wr_addr] <= wr_data;
      end
   end

   // Forward a write landing in the start cycle so the run sees the new entry.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         wgt_eff[i] = wgt_mem[i];
         ipt_eff[i] = ipt_mem[i];
         if (wr_ok && (wr_addr == AW'(i))) begin
            if (wr_sel) ipt_eff[i] = wr_data;
            else        wgt_eff[i] = wr_data;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
`ifdef ZERO_SKIP_EN
         issuable[i] = (AW1'(i) < len_use) && (|wgt_eff[i][DW-2:0]) && (|ipt_eff[i][DW-2:0]);
`else
         issuable[i] = (AW1'(i) < len_use);
`endif
      end
   end

   // An all-zero vector still issues pair 0 so the PE loads the bias.
   assign j1   = find_next(issuable, from_idx);
   assign j2   = find_next(issuable, j1 + AW1'(1));
   assign pick = (j1 == AW1'(DEPTH)) ? '0 : j1[AW-1:0];
   assign more = (j2 != AW1'(DEPTH));

   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      dcnt_n  = dcnt;
      wgt_n   = o_wgt;
      ipt_n   = o_ipt;
      psum_n  = o_psum;
      ctr_n   = o_accum_ctr;
      valid_n = 1'b0;
      issue   = 1'b0;
      case (state)
         S_IDLE: begin
            if (start_acc) begin
               psum_n = cfg_bias;
               if (len_cfg == '0) begin
                  state_n = S_DRAIN;
                  dcnt_n  = '0;
                  wgt_n   = '0;
                  ipt_n   = '0;
                  ctr_n   = 1'b1;
               end else begin
                  issue = 1'b1;
               end
            end
         end
         S_STREAM: issue = 1'b1;
         S_DRAIN: begin
            wgt_n = '0;
            ipt_n = '0;
            ctr_n = 1'b1;
            if (dcnt == '0) state_n = S_IDLE;
            else            dcnt_n  = dcnt - CW'(1);
         end
         default: state_n = S_IDLE;
      endcase
      if (issue) begin
         wgt_n   = wgt_eff[pick];
         ipt_n   = ipt_eff[pick];
         psum_n  = (state == S_IDLE) ? cfg_bias : bias_r;
         ctr_n   = (state != S_IDLE);
         valid_n = 1'b1;
         ptr_n   = {1'b0, pick} + AW1'(1);
         if (more) begin
            state_n = S_STREAM;
         end else begin
            // State already reads DRAIN while the last pair is on the outputs.
            state_n = S_DRAIN;
            dcnt_n  = CW'(PE_LAT);
         end
      end
      done_n = (state_n == S_DRAIN) && (dcnt_n == '0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         len_r       <= '0;
         ptr         <= '0;
         dcnt        <= '0;
         start_q     <= 1'b0;
         done        <= 1'b0;
         o_wgt       <= '0;
         o_ipt       <= '0;
         o_psum      <= '0;
         o_accum_ctr <= 1'b1;
         o_valid     <= 1'b0;
      end else begin
         state       <= state_n;
         ptr         <= ptr_n;
         dcnt        <= dcnt_n;
         start_q     <= start;
         done        <= done_n;
         o_wgt       <= wgt_n;
         o_ipt       <= ipt_n;
         o_psum      <= psum_n;
         o_accum_ctr <= ctr_n;
         o_valid     <= valid_n;
         if (start_acc) len_r <= len_cfg;
      end
   end

   always_ff @(posedge clk) begin
      if (start_acc) bias_r <= cfg_bias;
   end

endmodule
